// File: rtl/fsqrt_unit.sv
// fsqrt_unit: IEEE-754 binary32 square root, one-clock latency, one op per clock
// Ports: clk, rst (sync, active-high); x operand; y registered sqrt(x);
//   xaaa/hikare/ra/nib/an: registered last-step recurrence values for debug.
module fsqrt_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] x,
    output logic [31:0] y,
    output logic [23:0] xaaa,
    output logic [23:0] nib,
    output logic [23:0] hikare,
    output logic [23:0] ra,
    output logic [47:0] an
);
    logic        w_s;
    logic [7:0]  w_e;
    logic [22:0] w_m;
    logic [23:0] w_mant;
    logic [47:0] w_an;
    logic [8:0]  w_ey;
    logic [27:0] w_rem;
    logic [27:0] w_min;
    logic [27:0] w_trial;
    logic [23:0] w_root;
    logic [23:0] w_r;
    logic [31:0] w_y;
    logic [31:0] r_y;
    logic [23:0] r_xaaa;
    logic [23:0] r_nib;
    logic [23:0] r_hikare;
    logic [23:0] r_ra;
    logic [47:0] r_an;

    assign {w_s, w_e, w_m} = x;
    assign w_mant = {1'b1, w_m};
    // Odd biased exponent means even unbiased exponent: shift one less so the root lands in [2^23, 2^24).
    assign w_an = w_e[0] ? {1'b0, w_mant, 23'b0} : {w_mant, 24'b0};
    assign w_ey = ({1'b0, w_e} + 9'd127) >> 1;

    // Restoring integer square root, two radicand bits per step, MSB first.
    always_comb begin
        w_rem   = '0;
        w_root  = '0;
        w_min   = '0;
        w_trial = '0;
        for (int i = 23; i >= 0; i--) begin
            w_min   = {w_rem[25:0], w_an[2*i+1 -: 2]};
            w_trial = {2'b0, w_root, 2'b01};
            w_rem   = (w_min >= w_trial) ? w_min - w_trial : w_min;
            w_root  = {w_root[22:0], w_min >= w_trial};
        end
    end

    // Remainder above the root means the true root is past the half-way point.
    assign w_r = (w_rem > {4'b0, w_root}) ? w_root + 24'd1 : w_root;

    // The hidden bit r[23] is always set; it adds the 1 back onto ey-1.
    assign w_y = (w_e == 8'hFF && w_m != 23'd0) ? 32'h7FC00000 :
                 (w_e == 8'h00)                 ? {w_s, 31'b0} :
                 w_s                            ? 32'h7FC00000 :
                 (w_e == 8'hFF)                 ? 32'h7F800000 :
                 {w_ey - 9'd1, 23'b0} + {8'b0, w_r};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_y      <= '0;
            r_xaaa   <= '0;
            r_nib    <= '0;
            r_hikare <= '0;
            r_ra     <= '0;
            r_an     <= '0;
        end else begin
            r_y      <= w_y;
            r_xaaa   <= w_trial[23:0];
            r_nib    <= w_root;
            r_hikare <= w_min[23:0];
            r_ra     <= w_min[23:0] - w_trial[23:0];
            r_an     <= w_an;
        end
    end

    assign y      = r_y;
    assign xaaa   = r_xaaa;
    assign nib    = r_nib;
    assign hikare = r_hikare;
    assign ra     = r_ra;
    assign an     = r_an;
endmodule

// File: tb/tb_fsqrt_unit.sv
// tb_fsqrt_unit: randomized scoreboard bench for fsqrt_unit against a real-arithmetic sqrt model
module tb_fsqrt_unit;
    logic        clk;
    logic        rst;
    logic [31:0] x;
    logic [31:0] y;
    logic [23:0] xaaa;
    logic [23:0] nib;
    logic [23:0] hikare;
    logic [23:0] ra;
    logic [47:0] an;

    typedef struct packed {
        logic [31:0] x;
        logic [31:0] y;
        logic [47:0] an;
        logic [23:0] nib;
        logic [23:0] hik;
        logic [23:0] xa;
        logic        chk;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    fsqrt_unit dut (
        .clk(clk), .rst(rst), .x(x), .y(y),
        .xaaa(xaaa), .nib(nib), .hikare(hikare), .ra(ra), .an(an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [31:0] v, input logic rs);
        exp_t        e;
        logic        s;
        logic [7:0]  ex;
        logic [22:0] m;
        longint      a;
        longint      n;
        longint      r23;
        longint      tmp;
        logic [63:0] db;
        logic [63:0] dr;
        logic [10:0] fe;
        logic [31:0] t;
        e = '0;
        e.x = v;
        if (rs) begin
            e.chk = 1'b1;
            return e;
        end
        {s, ex, m} = v;
        if (ex == 8'hFF && m != 23'd0) e.y = 32'h7FC00000;
        else if (ex == 8'h00)          e.y = {s, 31'b0};
        else if (s)                    e.y = 32'h7FC00000;
        else if (ex == 8'hFF)          e.y = 32'h7F800000;
        else begin
            // Widen to double, take the correctly rounded double root, then round-to-nearest-even to float.
            db = {1'b0, {3'b0, ex} + 11'd896, m, 29'b0};
            dr = $realtobits($sqrt($bitstoreal(db)));
            fe = dr[62:52] - 11'd896;
            t  = {1'b0, fe[7:0], dr[51:29]};
            if (dr[28] && (dr[27:0] != 28'd0 || dr[29])) t = t + 32'd1;
            e.y = t;
            // Internals: aligned radicand, its integer root, and the last step's minuend/trial.
            a = longint'({1'b1, m});
            a = ex[0] ? a << 23 : a << 24;
            n = longint'($rtoi($sqrt(real'(a))));
            while (n * n > a) n--;
            while ((n + 1) * (n + 1) <= a) n++;
            r23   = n >> 1;
            e.an  = a[47:0];
            e.nib = n[23:0];
            tmp   = 4 * ((a >> 2) - r23 * r23) + (a & 3);
            e.hik = tmp[23:0];
            tmp   = 4 * r23 + 1;
            e.xa  = tmp[23:0];
            e.chk = 1'b1;
        end
        return e;
    endfunction

    task automatic apply(input logic [31:0] v, input logic rs);
        @(negedge clk);
        x   = v;
        rst = rs;
        q.push_back(model(v, rs));
    endtask

    initial begin
        exp_t ex;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                ex = q.pop_front();
                n_vec++;
                if (y !== ex.y) begin
                    n_bad++;
                    $display("FAIL y x=%h y=%h ref=%h nib=%h hikare=%h xaaa=%h ra=%h an=%h",
                             ex.x, y, ex.y, nib, hikare, xaaa, ra, an);
                end
                if (ex.chk) begin
                    if (an !== ex.an) begin
                        n_bad++;
                        $display("FAIL an x=%h got=%h want=%h", ex.x, an, ex.an);
                    end
                    if (nib !== ex.nib) begin
                        n_bad++;
                        $display("FAIL nib x=%h got=%h want=%h", ex.x, nib, ex.nib);
                    end
                    if (hikare !== ex.hik) begin
                        n_bad++;
                        $display("FAIL hikare x=%h got=%h want=%h", ex.x, hikare, ex.hik);
                    end
                    if (xaaa !== ex.xa) begin
                        n_bad++;
                        $display("FAIL xaaa x=%h got=%h want=%h", ex.x, xaaa, ex.xa);
                    end
                end
                if (ra !== 24'(hikare - xaaa)) begin
                    n_bad++;
                    $display("FAIL ra x=%h got=%h want=%h", ex.x, ra, 24'(hikare - xaaa));
                end
            end
        end
    end

    initial begin
        logic [31:0] dir [10];
        dir = '{32'h40800000, 32'h3F800000, 32'h40100000, 32'h40000000, 32'h00000000,
                32'h80000000, 32'hBF800000, 32'h7F800000, 32'h7FC00001, 32'h00400000};
        rst = 1'b1;
        x   = '0;
        apply(32'h40800000, 1'b1);
        apply(32'h40800000, 1'b1);
        foreach (dir[i]) apply(dir[i], 1'b0);
        for (int i = 0; i < 1500; i++) apply({1'b0, 8'd99, 23'($urandom)}, 1'b0);
        apply(32'h40100000, 1'b1);
        apply(32'h40800000, 1'b0);
        for (int i = 0; i < 1500; i++) apply({1'b0, 8'd160, 23'($urandom)}, 1'b0);
        apply({1'b0, 8'd99, 23'h000000}, 1'b0);
        apply({1'b0, 8'd99, 23'h7FFFFF}, 1'b0);
        apply({1'b0, 8'd160, 23'h7FFFFF}, 1'b0);
        apply({1'b0, 8'd1, 23'h000000}, 1'b0);
        apply({1'b0, 8'd254, 23'h7FFFFF}, 1'b0);
        for (int i = 0; i < 1000; i++) apply($urandom, 1'b0);
        for (int i = 0; i < 1000; i++) apply({1'b0, 8'($urandom_range(1, 254)), 23'($urandom)}, 1'b0);
        apply(32'h3F800000, 1'b1);
        apply(32'h40800000, 1'b0);
        repeat (3) @(negedge clk);
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain pending=%0d want=0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
